sha_round_controller: RTL and testbench

Sequences the shared round counter and round constant Kt that drive one or more sha_unit instances in lockstep, so the units no longer free-run.
- Runs a job of PASSES compression passes of 64 rounds each. Pass 0 is the block hash from the midstate; pass 1 is the re-hash for double SHA-256.
- Exposes a start/busy/done handshake to the job-level control logic.
- Provides pass and capture strobes so the datapath can switch the M/H0 muxes and latch H1 at the correct cycle.

---
 rtl/sha_round_controller.sv | 154 +++++++++++++++
 tb/tb_sha_round_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sha_round_controller.sv
// Round/pass sequencer for lockstep sha_unit instances: drives the shared round
// index, the matching SHA-256 constant Kt, and the job start/busy/done handshake.
module sha_round_controller #(
  parameter int PASSES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [5:0]  round,
  output logic [31:0] Kt,
  output logic        pass,
  output logic        capture
);

  generate
    if (PASSES < 1 || PASSES > 2) begin : g_bad_passes
      $error("sha_round_controller: PASSES must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic LAST_PASS = 1'(PASSES - 1);

  // FIPS 180-4 round constants: fractional parts of the cube roots of the first 64 primes.
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_e      state_q,   state_d;
  logic [5:0]  round_q,   round_d;
  logic        pass_q,    pass_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        capture_q, capture_d;
  logic [31:0] kt_q,      kt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    round_d   = round_q;
    pass_d    = pass_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    capture_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        round_d = 6'd0;
        pass_d  = 1'b0;
        if (start && !abort) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          round_d = 6'd0;
          pass_d  = 1'b0;
        end else if (round_q == 6'd63) begin
          round_d = 6'd0;
          if (pass_q != LAST_PASS) begin
            // Next pass starts on the very next cycle; no idle gap between passes.
            pass_d = pass_q + 1'b1;
            busy_d = 1'b1;
          end else begin
            state_d = S_DONE;
            pass_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          round_d   = round_q + 6'd1;
          busy_d    = 1'b1;
          capture_d = (round_d == 6'd63);
        end
      end

      S_DONE: begin
        round_d = 6'd0;
        pass_d  = 1'b0;
        if (start && !abort) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        round_d = 6'd0;
        pass_d  = 1'b0;
      end
    endcase

    // Indexed by the next round so the registered Kt lines up with round.
    kt_d = K_ROM[round_d];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      round_q   <= 6'd0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      capture_q <= 1'b0;
      kt_q      <= K_ROM[0];
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      capture_q <= capture_d;
      kt_q      <= kt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign round   = round_q;
  assign Kt      = kt_q;
  assign pass    = pass_q;
  assign capture = capture_q;

endmodule

// File: tb/tb_sha_round_controller.sv
// Bench for sha_round_controller: PASSES=1 and PASSES=2 instances checked every
// cycle against a job-age model and constants derived from prime cube roots.
module tb_sha_round_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i   [2];
  logic        abort_i   [2];
  logic        busy_o    [2];
  logic        done_o    [2];
  logic        pass_o    [2];
  logic        capture_o [2];
  logic [5:0]  round_o   [2];
  logic [31:0] kt_o      [2];

  always #5 clk = ~clk;

  sha_round_controller #(.PASSES(1)) u_dut_p1 (
    .clk(clk), .reset_n(reset_n), .start(start_i[0]), .abort(abort_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .round(round_o[0]), .Kt(kt_o[0]),
    .pass(pass_o[0]), .capture(capture_o[0])
  );

  sha_round_controller #(.PASSES(2)) u_dut_p2 (
    .clk(clk), .reset_n(reset_n), .start(start_i[1]), .abort(abort_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .round(round_o[1]), .Kt(kt_o[1]),
    .pass(pass_o[1]), .capture(capture_o[1])
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] k_ref [64];
  int          passes [2] = '{1, 2};
  // Age of the current job in cycles: 0 = no job, 1..64*P = rounds, 64*P+1 = done cycle.
  int          age [2] = '{0, 0};
  int          cyc;
  int          done_cnt [2];
  int          done_at [2];
  int          capture_cnt [2];
  logic [31:0] kt_at_capture [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // K[i] = first 32 fractional bits of cbrt(i-th prime), refined by one Newton step.
  function automatic void build_k();
    int  p;
    int  n;
    bit  is_p;
    real r;
    real fr;
    p = 2;
    n = 0;
    while (n < 64) begin
      is_p = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) is_p = 1'b0;
      if (is_p) begin
        r  = $pow(real'(p), 1.0 / 3.0);
        r  = r - (r * r * r - real'(p)) / (3.0 * r * r);
        fr = r - $floor(r);
        k_ref[n] = 32'(longint'($floor(fr * 4294967296.0)));
        n++;
      end
      p++;
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int   last;
      logic b;
      int   r;
      int   ps;
      last = 64 * passes[i];
      b    = (age[i] >= 1) && (age[i] <= last);
      r    = b ? (age[i] - 1) % 64 : 0;
      ps   = b ? (age[i] - 1) / 64 : 0;
      check($sformatf("p%0d busy age=%0d", passes[i], age[i]), 32'(busy_o[i]), 32'(b));
      check($sformatf("p%0d done age=%0d", passes[i], age[i]), 32'(done_o[i]), 32'(age[i] == last + 1));
      check($sformatf("p%0d round age=%0d", passes[i], age[i]), 32'(round_o[i]), 32'(r));
      check($sformatf("p%0d pass age=%0d", passes[i], age[i]), 32'(pass_o[i]), 32'(ps));
      check($sformatf("p%0d capture age=%0d", passes[i], age[i]), 32'(capture_o[i]), 32'(b && r == 63));
      check($sformatf("p%0d Kt age=%0d", passes[i], age[i]), kt_o[i], k_ref[r]);
    end
  endtask

  task automatic clear_tallies();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      done_at[i] = 0;
      capture_cnt[i] = 0;
      kt_at_capture[i] = '0;
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model on the rising edge,
  // then compare on the following falling edge.
  task automatic step(input logic s0, input logic a0, input logic s1, input logic a1);
    start_i[0] = s0;
    abort_i[0] = a0;
    start_i[1] = s1;
    abort_i[1] = a1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (abort_i[i])                        age[i] = 0;
      else if (age[i] == 0)                  age[i] = start_i[i] ? 1 : 0;
      else if (age[i] == 64 * passes[i] + 1) age[i] = start_i[i] ? 1 : 0;
      else                                   age[i] = age[i] + 1;
    end
    @(negedge clk);
    cyc++;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      if (done_o[i] === 1'b1) begin
        done_cnt[i]++;
        done_at[i] = cyc;
      end
      if (capture_o[i] === 1'b1) begin
        capture_cnt[i]++;
        kt_at_capture[i] = kt_o[i];
      end
    end
  endtask

  initial begin
    build_k();
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0;
      abort_i[i] = 1'b0;
    end

    // Reset values.
    repeat (2) @(negedge clk);
    check_outputs();
    check("reset Kt p1", kt_o[0], 32'h428a2f98);
    reset_n = 1'b1;
    @(negedge clk);

    // Single job on each instance.
    clear_tallies();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (140) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("p%0d single done count", passes[i]), 32'(done_cnt[i]), 32'd1);
      check($sformatf("p%0d single done cycle", passes[i]), 32'(done_at[i]), 32'(64 * passes[i] + 1));
      check($sformatf("p%0d single capture count", passes[i]), 32'(capture_cnt[i]), 32'(passes[i]));
      check($sformatf("p%0d Kt at round 63", passes[i]), kt_at_capture[i], 32'hc67178f2);
    end

    // start held high: back-to-back jobs.
    clear_tallies();
    repeat (400) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      check($sformatf("p%0d back-to-back jobs", passes[i]), 32'(done_cnt[i]), 32'(400 / (64 * passes[i] + 1)));
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Abort the PASSES=2 job at pass 1, round 30.
    clear_tallies();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 200 && age[1] != 95; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort point reached", 32'({pass_o[1], round_o[1]}), 32'({1'b1, 6'd30}));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("after abort Kt", kt_o[1], 32'h428a2f98);
    repeat (150) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("aborted job no done", 32'(done_cnt[1]), 32'd0);
    clear_tallies();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (140) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("clean job after abort", 32'(done_cnt[1]), 32'd1);
    check("clean job done cycle", 32'(done_at[1]), 32'd129);

    // Asynchronous reset mid-job at pass 0, round 40.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 200 && age[1] != 41; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    age[0] = 0;
    age[1] = 0;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    clear_tallies();
    repeat (150) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      check($sformatf("p%0d no done after reset", passes[i]), 32'(done_cnt[i]), 32'd0);

    // Random start/abort traffic against the model.
    repeat (3000)
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
